freq_counter_mc: RTL and testbench
==================================

# freq_counter_mc

Multi-channel reciprocal frequency counter with a Wishbone slave port. It generalises the single-channel counter to N_CH inputs, a programmable gate length, saturation and overflow reporting, and an optional timeout. Everything runs in the single clk_i domain. Each input is synchronised, and its period is measured as clk_i cycles over a programmable number of input periods. It sits on the peripheral Wishbone bus beside the existing counter.

## Interface
- N_CH, 4: number of input channels, 1..8
- CNT_W, 32: result counter width, 16..32
- GATE_W, 16: gate-length register width, in input periods
- SYNC_STAGES, 2: input synchroniser depth, ≥2
- clk_i  in  1  bus and reference clock; all logic on its rising edge
- ext_rst_i  in  1  asynchronous, active-low reset
- addr_i  in  32  byte address; bits [5:2] decoded
- dat_i  in  32  write data
- we_i  in  1  write enable
- sel_i  in  4  byte select; ignored, all writes are full-word
- cyc_i, stb_i  in  1 each  Wishbone cycle and strobe
- sig_i  in  N_CH  asynchronous signals under test
- dat_o  out  32  read data; reset value 0
- ack_o, err_o, rty_o  out  1 each  reset value 0; rty_o is tied to 0
- irq_o  out  1  level output: OR of the done bits; reset value 0

## Operation
- Registers, by byte offset:
  - 0x00 CTRL (RW): [N_CH-1:0] channel enable mask. Writing a 1 to bit 31 issues a start pulse; writing a 1 to bit 30 issues an abort pulse. Bits 31 and 30 read as 0.
  - 0x04 GATE (RW): gate length G in input periods; G=0 is treated as 1.
  - 0x08 STATUS (RO): [7:0] busy, [15:8] done, [23:16] overflow, [31:24] timeout. Each field holds one bit per channel.
  - 0x0C TIMEOUT (RW, only when the feature is compiled in).
  - 0x10+4·ch COUNT[ch] (RO): last result, zero-extended.
- Bus access:
  - Any unmapped offset, or any write to an RO register, returns err_o instead of ack_o.
  - Reads of unmapped offsets return dat_o=0.
- Per-channel state machine: IDLE → ARM → MEAS → IDLE.
  - IDLE→ARM: start with the channel enabled. At this transition G is latched, the counter is cleared, and the done, overflow and timeout flags are cleared.
  - ARM→MEAS: first synchronised rising edge. The period counter is set to 0 and the cycle counter to 1.
  - MEAS: the cycle counter increments every clk_i cycle. Each rising edge increments the period counter. When the period counter reaches G on an edge, COUNT latches the cycle count, done is set, and the channel returns to IDLE.
  - Abort in ARM or MEAS: return to IDLE. COUNT keeps its old value and done is not set.
- Start rules:
  - A start while any channel is busy is ignored entirely.
  - A start with an enable mask of 0 does nothing.
- Arithmetic: for a clean input of period P cycles, COUNT = G·P exactly. The synchroniser delay cancels because both gate edges see the same delay.
- Saturation: the cycle counter saturates at 2^CNT_W−1 and sets overflow. The measurement still completes on edge G, and COUNT then reads all-ones.
- Writes during a measurement: writing GATE or the enable mask while busy affects only the next start.

## Timing
- Input path: SYNC_STAGES flops plus one edge-detect flop, so an edge is seen SYNC_STAGES+1 cycles after the sig_i rise.
- Bus handshake:
  - ack_o/err_o is registered and asserted for exactly one cycle, in the cycle after cyc_i&stb_i is sampled with ack_o=0.
  - There is no back-to-back ack; a held strobe gets one response every two cycles.
  - dat_o is valid in the ack cycle.
- Start latency: a start written in cycle T puts the channel in ARM at T+1. An edge detected at T+1 is missed; the first usable edge is at T+2.
- Done latency: done is visible in STATUS and on irq_o one cycle after the G-th edge is detected.
- Simultaneous events:
  - Abort beats both edge and completion in the same cycle.
  - A COUNT read in the completion cycle returns the old value.
- Reset: ext_rst_i low asynchronously clears all state, registers, outputs and synchroniser flops. GATE resets to 1, TIMEOUT to 0xFFFF_FFFF, CTRL to 0.

## Configuration
- Macro FREQ_COUNTER_MC_TIMEOUT_EN.
- Defined:
  - A per-channel timeout counter runs during ARM and MEAS.
  - When it reaches TIMEOUT, the channel sets timeout and done, COUNT becomes all-ones, and the channel returns to IDLE.
  - TIMEOUT is mapped at 0x0C.
- Undefined:
  - No timeout logic is built; a channel waits indefinitely and only abort frees it.
  - Offset 0x0C is unmapped and returns err_o.
  - STATUS[31:24] reads 0.

## Structure
- Package freq_counter_mc_pkg holds:
  - register offset constants;
  - STATUS field base constants;
  - the channel state enum (IDLE, ARM, MEAS).
- Sub-module freq_counter_mc_channel: synchroniser, edge detect, state machine, counters and result register. It is instantiated N_CH times by a generate loop.
- The top level holds the Wishbone decode, CTRL, GATE and TIMEOUT registers, STATUS assembly and irq_o.

## Test plan
- Reset: drive ext_rst_i low mid-measurement → all outputs 0, STATUS=0, GATE reads 1, CTRL reads 0.
- Basic measurement: ch0 at period 10 cycles, G=100, enable=0x1, start → COUNT[0]=1000, STATUS done[0]=1, irq_o=1.
- Multi-channel: ch0–ch3 at periods 7, 13, 50, 1000, G=16 → COUNTs 112, 208, 800, 16000; done=0xF.
- Saturation: CNT_W=16, period 5000, G=20 → COUNT=0xFFFF, overflow[0]=1, done[0]=1.
- Abort and restart: abort during MEAS → busy clears, COUNT unchanged, done=0. A start during busy is ignored. G=0 behaves as G=1.
- Bus errors and timeout:
  - Read 0x3C → err_o for one cycle, dat_o=0. Write STATUS → err_o.
  - With FREQ_COUNTER_MC_TIMEOUT_EN defined, TIMEOUT=500 and no input edges → timeout[0]=1 and done[0]=1 at about 500 cycles, COUNT[0]=0xFFFF_FFFF.

Source files
------------

// File: rtl/freq_counter_mc_pkg.sv
// Shared constants and types for the multi-channel reciprocal frequency counter.
// Optional timeout support is selected with FREQ_COUNTER_MC_TIMEOUT_EN.
package freq_counter_mc_pkg;

    // Word index (addr[5:2]) of each register
    localparam logic [3:0] RegCtrl    = 4'h0;
    localparam logic [3:0] RegGate    = 4'h1;
    localparam logic [3:0] RegStatus  = 4'h2;
    localparam logic [3:0] RegTimeout = 4'h3;
    localparam logic [3:0] RegCount0  = 4'h4;

    localparam int unsigned StatBusyLsb = 0;
    localparam int unsigned StatDoneLsb = 8;
    localparam int unsigned StatOvfLsb  = 16;
    localparam int unsigned StatTmoLsb  = 24;

    localparam int unsigned CtrlStartBit = 31;
    localparam int unsigned CtrlAbortBit = 30;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeas
    } ch_state_e;

endpackage

// File: rtl/freq_counter_mc_channel.sv
// One measurement channel: input synchroniser, rising-edge detect, IDLE/ARM/MEAS
// state machine, saturating cycle counter and result register (FREQ_COUNTER_MC_TIMEOUT_EN).
module freq_counter_mc_channel
    import freq_counter_mc_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned GATE_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sig_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [GATE_W-1:0] gate_i,
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
    input  logic [31:0]       timeout_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic              tmo_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    ch_state_e         state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [GATE_W-1:0] per_q, per_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
    logic [31:0]       tcnt_q, tcnt_d;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        per_d   = per_q;
        cyc_d   = cyc_q;
        count_d = count_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StArm;
                    gate_d  = (gate_i == '0) ? GATE_W'(1) : gate_i;
                    per_d   = '0;
                    cyc_d   = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            StArm: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (rise) begin
                    state_d = StMeas;
                    per_d   = '0;
                    cyc_d   = CNT_W'(1);
                end
            end
            StMeas: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (rise && (per_q + GATE_W'(1) == gate_q)) begin
                    count_d = cyc_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    if (rise) per_d = per_q + GATE_W'(1);
                    // Hold at all-ones once full; the gate still closes normally
                    if (cyc_q == CntMax) ovf_d = 1'b1;
                    else                 cyc_d = cyc_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
        // Completion and abort take precedence over an expiring timeout
        if (state_q != StIdle && state_d != StIdle) begin
            if (tcnt_q == timeout_i) begin
                tmo_d   = 1'b1;
                done_d  = 1'b1;
                count_d = CntMax;
                state_d = StIdle;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gate_q  <= GATE_W'(1);
            per_q   <= '0;
            cyc_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            per_q   <= per_d;
            cyc_q   <= cyc_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;
    assign ovf_o   = ovf_q;
    assign tmo_o   = tmo_q;
    assign count_o = count_q;

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel reciprocal frequency counter with a Wishbone slave register port.
// Defining FREQ_COUNTER_MC_TIMEOUT_EN adds the TIMEOUT register and per-channel timeouts.
module freq_counter_mc
    import freq_counter_mc_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned GATE_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            ext_rst_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     dat_i,
    input  logic            we_i,
    input  logic [3:0]      sel_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic [N_CH-1:0] sig_i,
    output logic [31:0]     dat_o,
    output logic            ack_o,
    output logic            err_o,
    output logic            rty_o,
    output logic            irq_o
);

    logic [N_CH-1:0]   en_q;
    logic [GATE_W-1:0] gate_q;
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
    logic [31:0]       tmo_reg_q;
`endif
    logic              ack_q, err_q;
    logic [31:0]       dat_q;

    logic [N_CH-1:0]  busy, done, ovf, tmo, ch_start;
    logic [CNT_W-1:0] count [N_CH];

    logic        req, mapped, ro, ok, wr_en, ctrl_wr, abort, start_any;
    logic [3:0]  idx;
    logic [31:0] rdata, status;
    logic        unused_bus;

    assign unused_bus = ^{sel_i, addr_i[31:6], addr_i[1:0], dat_i};

    // A response cycle blocks sampling, so a held strobe is answered every other cycle
    assign req = cyc_i & stb_i & ~ack_q & ~err_q;
    assign idx = addr_i[5:2];

    always_comb begin
        status = '0;
        status[StatBusyLsb +: N_CH] = busy;
        status[StatDoneLsb +: N_CH] = done;
        status[StatOvfLsb  +: N_CH] = ovf;
        status[StatTmoLsb  +: N_CH] = tmo;
    end

    always_comb begin
        rdata  = '0;
        mapped = 1'b0;
        ro     = 1'b0;
        case (idx)
            RegCtrl: begin
                mapped = 1'b1;
                rdata  = 32'(en_q);
            end
            RegGate: begin
                mapped = 1'b1;
                rdata  = 32'(gate_q);
            end
            RegStatus: begin
                mapped = 1'b1;
                ro     = 1'b1;
                rdata  = status;
            end
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
            RegTimeout: begin
                mapped = 1'b1;
                rdata  = tmo_reg_q;
            end
`endif
            default: begin
                for (int unsigned c = 0; c < N_CH; c++) begin
                    if (idx == RegCount0 + 4'(c)) begin
                        mapped = 1'b1;
                        ro     = 1'b1;
                        rdata  = 32'(count[c]);
                    end
                end
            end
        endcase
    end

    assign ok        = mapped & ~(we_i & ro);
    assign wr_en     = req & we_i & ok;
    assign ctrl_wr   = wr_en & (idx == RegCtrl);
    assign abort     = ctrl_wr & dat_i[CtrlAbortBit];
    assign start_any = ctrl_wr & dat_i[CtrlStartBit] & ~dat_i[CtrlAbortBit] & ~(|busy);
    assign ch_start  = {N_CH{start_any}} & dat_i[N_CH-1:0];

    always_ff @(posedge clk_i or negedge ext_rst_i) begin
        if (!ext_rst_i) begin
            en_q      <= '0;
            gate_q    <= GATE_W'(1);
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
            tmo_reg_q <= '1;
`endif
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            ack_q <= req & ok;
            err_q <= req & ~ok;
            dat_q <= (req & ~we_i & mapped) ? rdata : '0;
            if (wr_en) begin
                case (idx)
                    RegCtrl:    en_q      <= dat_i[N_CH-1:0];
                    RegGate:    gate_q    <= dat_i[GATE_W-1:0];
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
                    RegTimeout: tmo_reg_q <= dat_i;
`endif
                    default: ;
                endcase
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        freq_counter_mc_channel #(
            .CNT_W       (CNT_W),
            .GATE_W      (GATE_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (ext_rst_i),
            .sig_i     (sig_i[c]),
            .start_i   (ch_start[c]),
            .abort_i   (abort),
            .gate_i    (gate_q),
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
            .timeout_i (tmo_reg_q),
`endif
            .busy_o    (busy[c]),
            .done_o    (done[c]),
            .ovf_o     (ovf[c]),
            .tmo_o     (tmo[c]),
            .count_o   (count[c])
        );
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;
    assign rty_o = 1'b0;
    assign irq_o = |done;

endmodule

// File: tb/tb_freq_counter_mc.sv
// Self-checking bench for freq_counter_mc: register table, bus corner cases and
// measurements against a model computed as min(G*P, all-ones) per channel.
module tb_freq_counter_mc;

    localparam logic [31:0] ACtrl = 32'h00, AGate = 32'h04, AStat = 32'h08, ATmo = 32'h0C;
    localparam logic [31:0] ACnt0 = 32'h10;
    localparam longint      CMax  = 65535;

    logic        clk, rst_n, we, cyc, stb, ack, err, rty, irq;
    logic [31:0] addr, wdat, rdat;
    logic [3:0]  sel;
    logic [3:0]  sig;

    int n_vec = 0;
    int n_fail = 0;

    int unsigned per [4] = '{0, 0, 0, 0};
    int unsigned ph  [4] = '{0, 0, 0, 0};

    logic [15:0] m_cnt  [4];
    logic        m_done [4];
    logic        m_ovf  [4];
    logic        m_tmo  [4];

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        exp_err;
        logic [31:0] exp_dat;
        string       nm;
    } vec_t;
    vec_t vt[$];

    freq_counter_mc #(
        .N_CH        (4),
        .CNT_W       (16),
        .GATE_W      (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i     (clk),
        .ext_rst_i (rst_n),
        .addr_i    (addr),
        .dat_i     (wdat),
        .we_i      (we),
        .sel_i     (sel),
        .cyc_i     (cyc),
        .stb_i     (stb),
        .sig_i     (sig),
        .dat_o     (rdat),
        .ack_o     (ack),
        .err_o     (err),
        .rty_o     (rty),
        .irq_o     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square wave of per[c] cycles per channel (high for per/2 cycles), 0 when per < 2
    always @(posedge clk) begin
        #2;
        for (int c = 0; c < 4; c++) begin
            if (per[c] < 2) begin
                ph[c]  = 0;
                sig[c] = 1'b0;
            end else begin
                ph[c]  = (ph[c] + 1) % per[c];
                sig[c] = (ph[c] < per[c] / 2);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                           output logic [31:0] rd, output logic ak, output logic er);
        addr = a; wdat = d; we = w; cyc = 1'b1; stb = 1'b1;
        ak = 1'b0; er = 1'b0; rd = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                ak = ack; er = err; rd = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!ak && !er) begin
            n_vec++; n_fail++;
            $display("FAIL bus_timeout: addr 0x%08h got no response, expected ack or err", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic ak, er;
        wb_xfer(a, d, 1'b1, rd, ak, er);
        check("write_ack", {30'd0, ak, er}, 32'd2);
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        logic ak, er;
        wb_xfer(a, 32'd0, 1'b0, d, ak, er);
    endtask

    task automatic check_status(input string nm, input logic [3:0] busy_exp);
        logic [31:0] s, e;
        e = '0;
        e[3:0] = busy_exp;
        for (int c = 0; c < 4; c++) begin
            e[8 + c]  = m_done[c];
            e[16 + c] = m_ovf[c];
            e[24 + c] = m_tmo[c];
        end
        rd_reg(AStat, s);
        check(nm, s, e);
    endtask

    task automatic check_counts(input string nm);
        logic [31:0] v;
        logic        any;
        any = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rd_reg(ACnt0 + 32'(4 * c), v);
            check($sformatf("%s_count%0d", nm, c), v, {16'd0, m_cnt[c]});
            any |= m_done[c];
        end
        check({nm, "_irq"}, {31'd0, irq}, {31'd0, any});
    endtask

    task automatic wait_idle(input int budget, input string nm);
        logic [31:0] s;
        bit          idle;
        int          used;
        idle = 0; used = 0;
        while (!idle && used < budget) begin
            rd_reg(AStat, s);
            used += 2;
            idle = (s[7:0] == 8'd0);
        end
        if (!idle) begin
            n_vec++; n_fail++;
            $display("FAIL %s_wait: busy=0x%02h after %0d cycles, expected 0x00", nm, s[7:0], used);
        end
    endtask

    task automatic run_meas(input logic [3:0] mask, input int unsigned g, input int budget,
                            input string nm);
        longint prod;
        int unsigned geff;
        geff = (g == 0) ? 1 : g;
        wr(AGate, 32'(g));
        wr(ACtrl, 32'h8000_0000 | 32'(mask));
        for (int c = 0; c < 4; c++) if (mask[c]) begin
            m_done[c] = 1'b0; m_ovf[c] = 1'b0; m_tmo[c] = 1'b0;
        end
        wait_idle(budget, nm);
        for (int c = 0; c < 4; c++) if (mask[c]) begin
            prod      = longint'(geff) * longint'(per[c]);
            m_cnt[c]  = (prod > CMax) ? 16'hFFFF : prod[15:0];
            m_ovf[c]  = (prod > CMax);
            m_done[c] = 1'b1;
        end
        check_status({nm, "_status"}, 4'h0);
        check_counts(nm);
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] d, input logic w,
                           input logic ee, input logic [31:0] ed, input string nm);
        vec_t v;
        v.a = a; v.d = d; v.w = w; v.exp_err = ee; v.exp_dat = ed; v.nm = nm;
        vt.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ak, er, prev_ack;
        int          nack, b2b;

        rst_n = 1'b0; addr = '0; wdat = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; sel = 4'hF;
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = '0; m_done[c] = 1'b0; m_ovf[c] = 1'b0; m_tmo[c] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_dat", rdat, 32'd0);
        check("reset_flags", {28'd0, ack, err, rty, irq}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Register / decode table, applied from idle
        add_vec(ACtrl, 32'h0000_0005, 1'b1, 1'b0, 32'd0, "ctrl_wr");
        add_vec(ACtrl, 32'd0, 1'b0, 1'b0, 32'h0000_0005, "ctrl_rd");
        add_vec(ACtrl, 32'h4000_000A, 1'b1, 1'b0, 32'd0, "ctrl_wr_abort");
        add_vec(ACtrl, 32'd0, 1'b0, 1'b0, 32'h0000_000A, "ctrl_rd_nopulse");
        add_vec(AGate, 32'h0001_1234, 1'b1, 1'b0, 32'd0, "gate_wr");
        add_vec(AGate, 32'd0, 1'b0, 1'b0, 32'h0000_1234, "gate_rd");
        add_vec(AStat, 32'd0, 1'b0, 1'b0, 32'd0, "status_rd_idle");
        add_vec(AStat, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, "status_wr_err");
        add_vec(32'h3C, 32'd0, 1'b0, 1'b1, 32'd0, "unmapped_3c_rd");
        add_vec(ACnt0, 32'h1234, 1'b1, 1'b1, 32'd0, "count0_wr_err");
        add_vec(ACnt0, 32'd0, 1'b0, 1'b0, 32'd0, "count0_rd_reset");
        add_vec(32'h20, 32'd0, 1'b0, 1'b1, 32'd0, "count4_unmapped");
`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
        add_vec(ATmo, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, "timeout_rd_reset");
`else
        add_vec(ATmo, 32'd0, 1'b0, 1'b1, 32'd0, "timeout_unmapped");
`endif
        foreach (vt[i]) begin
            wb_xfer(vt[i].a, vt[i].d, vt[i].w, rd, ak, er);
            check({vt[i].nm, "_resp"}, {30'd0, ak, er}, vt[i].exp_err ? 32'd1 : 32'd2);
            if (!vt[i].w) check({vt[i].nm, "_dat"}, rd, vt[i].exp_dat);
        end

        // Held strobe: one response every two cycles, never back-to-back
        addr = AGate; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        nack = 0; b2b = 0; prev_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) nack++;
            if (ack && prev_ack) b2b++;
            prev_ack = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_strobe_acks", 32'(nack), 32'd3);
        check("held_strobe_b2b", 32'(b2b), 32'd0);
        @(posedge clk); #1;

        // Basic measurement
        per[0] = 10;
        run_meas(4'h1, 100, 3000, "basic");

        // Multi-channel; ch3 runs long enough to saturate the 16-bit counter
        per[0] = 7; per[1] = 13; per[2] = 50; per[3] = 4097;
        run_meas(4'hF, 16, 70000, "multi");

        // Abort during MEAS, with a start during busy in between
        per[0] = 10;
        wr(AGate, 32'd100);
        wr(ACtrl, 32'h8000_0001);
        m_done[0] = 1'b0; m_ovf[0] = 1'b0; m_tmo[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_status("abort_busy", 4'h1);
        wr(ACtrl, 32'h8000_0002);
        check_status("start_while_busy", 4'h1);
        wr(ACtrl, 32'h4000_0001);
        check_status("abort_idle", 4'h0);
        check_counts("abort");

        // G=0 acts as G=1
        per[0] = 10;
        run_meas(4'h1, 0, 500, "gate0");

        // Start with an empty mask does nothing
        wr(ACtrl, 32'h8000_0000);
        check_status("start_mask0", 4'h0);

        // Randomised measurements
        for (int k = 0; k < 6; k++) begin
            logic [3:0]  mask;
            int unsigned g;
            mask = 4'($urandom_range(1, 15));
            g    = $urandom_range(0, 20);
            for (int c = 0; c < 4; c++) per[c] = $urandom_range(2, 60);
            run_meas(mask, g, 3000, $sformatf("rand%0d", k));
        end

`ifdef FREQ_COUNTER_MC_TIMEOUT_EN
        per[0] = 0;
        wr(ATmo, 32'd500);
        wr(AGate, 32'd10);
        wr(ACtrl, 32'h8000_0001);
        m_done[0] = 1'b0; m_ovf[0] = 1'b0; m_tmo[0] = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        check_status("timeout_pending", 4'h1);
        wait_idle(1000, "timeout");
        m_done[0] = 1'b1; m_tmo[0] = 1'b1; m_cnt[0] = 16'hFFFF;
        check_status("timeout_status", 4'h0);
        check_counts("timeout");
`endif

        // Asynchronous reset in the middle of a measurement
        per[0] = 10;
        wr(AGate, 32'd100);
        wr(ACtrl, 32'h8000_0001);
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {28'd0, ack, err, rty, irq}, 32'd0);
        check("midrst_dat", rdat, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = '0; m_done[c] = 1'b0; m_ovf[c] = 1'b0; m_tmo[c] = 1'b0;
        end
        check_status("postrst_status", 4'h0);
        rd_reg(AGate, rd);
        check("postrst_gate", rd, 32'd1);
        rd_reg(ACtrl, rd);
        check("postrst_ctrl", rd, 32'd0);
        check_counts("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
